// File: rtl/mult_div_if.sv
// rtl/mult_div_if.sv - start/busy/done handshake and HI/LO result bus of the mult/div unit
interface mult_div_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, opA, opB,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, opA, opB,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-bit MIPS mult(u)/div(u) unit writing HI/LO
// Signed mult/div sign handling is built only when `MULTDIV_SIGNED_EN is defined.
module mult_div_unit #(
  parameter int ITER = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  mult_div_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        is_div;
  logic        dz_q;
  logic        last;
  logic [31:0] div_q;      // multiplicand (mult) or divisor (div) magnitude
  logic [63:0] acc;        // {partial product, multiplier} or {remainder, quotient}
  logic [63:0] acc_step;
  logic [63:0] res;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] rem_sh;
  logic [32:0] sum;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

`ifdef MULTDIV_SIGNED_EN
  logic        sgn_op;
  logic        signed_q;
  logic        neg_a_q;
  logic        neg_b_q;
  logic [31:0] raw_a_q;

  assign sgn_op = bus.op[1];
  assign mag_a  = (sgn_op && bus.opA[31]) ? (~bus.opA + 32'd1) : bus.opA;
  assign mag_b  = (sgn_op && bus.opB[31]) ? (~bus.opB + 32'd1) : bus.opB;
`else
  assign mag_a  = bus.opA;
  assign mag_b  = bus.opB;
`endif

  assign last = (cnt == 5'(ITER - 1));

  // One iteration: shift-add for multiply, restoring trial subtract for divide
  always_comb begin
    rem_sh = acc[63:31];
    sum    = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? div_q : 32'd0)};
    if (is_div) begin
      if (rem_sh >= {1'b0, div_q}) begin
        acc_step = {rem_sh[31:0] - div_q, acc[30:0], 1'b1};
      end else begin
        acc_step = {acc[62:0], 1'b0};
      end
    end else begin
      acc_step = {sum, acc[31:1]};
    end
  end

  always_comb begin
    res = acc_step;
`ifdef MULTDIV_SIGNED_EN
    if (signed_q) begin
      if (!is_div) begin
        if (neg_a_q ^ neg_b_q) res = -acc_step;
      end else if (dz_q) begin
        // Zero divisor reports the raw dividend, not its magnitude
        res = {raw_a_q, 32'hFFFF_FFFF};
      end else begin
        if (neg_a_q ^ neg_b_q) res[31:0]  = -acc_step[31:0];
        if (neg_a_q)           res[63:32] = -acc_step[63:32];
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (state == RUN);
    bus.done        = (state == FIN);
    bus.div_by_zero = (state == FIN) && dz_q;
    bus.hi          = hi_q;
    bus.lo          = lo_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      is_div <= 1'b0;
      dz_q   <= 1'b0;
      div_q  <= '0;
      acc    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
`ifdef MULTDIV_SIGNED_EN
      signed_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      raw_a_q  <= '0;
`endif
    end else if (state == IDLE && bus.start) begin
      cnt    <= '0;
      is_div <= bus.op[0];
      dz_q   <= bus.op[0] && (bus.opB == 32'd0);
      div_q  <= mag_b;
      acc    <= {32'd0, mag_a};
`ifdef MULTDIV_SIGNED_EN
      signed_q <= sgn_op;
      neg_a_q  <= sgn_op && bus.opA[31];
      neg_b_q  <= sgn_op && bus.opB[31];
      raw_a_q  <= bus.opA;
`endif
    end else if (state == RUN) begin
      acc <= acc_step;
      cnt <= cnt + 5'd1;
      // HI/LO take the final step directly so they are valid throughout FIN
      if (last) begin
        hi_q <= res[63:32];
        lo_q <= res[31:0];
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit with a reference arithmetic model
module tb_mult_div_unit;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  exp_t        sb[$];

  mult_div_if bus ();

  mult_div_unit #(.ITER(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Returns {div_by_zero, hi, lo}
  function automatic logic [64:0] model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] r;
    logic        dz;
    longint      sa, sb2, q, m;
    dz = 1'b0;
`ifdef MULTDIV_SIGNED_EN
    if (op[1]) begin
      sa  = longint'($signed(a));
      sb2 = longint'($signed(b));
      if (!op[0]) begin
        q = sa * sb2;
        r = q;
      end else if (b == 32'd0) begin
        r  = {a, 32'hFFFF_FFFF};
        dz = 1'b1;
      end else begin
        q = sa / sb2;
        m = sa % sb2;
        r = {m[31:0], q[31:0]};
      end
      return {dz, r};
    end
`endif
    if (!op[0]) begin
      r = {32'd0, a} * {32'd0, b};
    end else if (b == 32'd0) begin
      r  = {a, 32'hFFFF_FFFF};
      dz = 1'b1;
    end else begin
      r = {a % b, a / b};
    end
    return {dz, r};
  endfunction

  // Monitor: every cycle compares handshake and HI/LO against the scoreboard head
  always @(negedge clk) begin
    exp_t h;
    logic exp_done;
    logic exp_busy;
    if (rst_n) begin
      exp_done = 1'b0;
      exp_busy = 1'b0;
      if (sb.size() > 0) begin
        h        = sb[0];
        exp_done = (cyc == h.done_cyc);
        exp_busy = (cyc >= h.done_cyc - 32) && (cyc < h.done_cyc);
      end
      chk("busy", bus.busy, exp_busy);
      chk("done", bus.done, exp_done);
      if (exp_done) begin
        chk("hi", bus.hi, h.hi);
        chk("lo", bus.lo, h.lo);
        chk("div_by_zero", bus.div_by_zero, h.dz);
        model_hi = h.hi;
        model_lo = h.lo;
        void'(sb.pop_front());
      end else begin
        chk("div_by_zero_idle", bus.div_by_zero, 1'b0);
        chk("hi_hold", bus.hi, model_hi);
        chk("lo_hold", bus.lo, model_lo);
      end
    end
  end

  // Called at a negedge; lag is the number of rising edges until the DUT accepts
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lag);
    logic [64:0] r;
    exp_t        e;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.opA    = a;
    bus.opB    = b;
    r          = model(op, a, b);
    e.dz       = r[64];
    e.hi       = r[63:32];
    e.lo       = r[31:0];
    e.done_cyc = cyc + lag + 32;
    sb.push_back(e);
    repeat (lag) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Scrambles the operands and pulses start during RUN; returns at the done negedge
  task automatic wait_done();
    for (int i = 1; i <= 60; i++) begin
      if (bus.done) return;
      bus.start = (i == 5) || (i == 20);
      bus.op    = 2'($urandom);
      bus.opA   = $urandom;
      bus.opB   = $urandom;
      @(negedge clk);
    end
    compared++;
    mismatched++;
    $display("FAIL done_timeout: got no done expected done within 60 cycles");
    sb.delete();
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit b2b);
    if (!b2b) @(negedge clk);
    issue(op, a, b, b2b ? 2 : 1);
    wait_done();
  endtask

  initial begin
    logic [31:0] a, b;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.opA   = '0;
    bus.opB   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_dz", bus.div_by_zero, 1'b0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    run_op(2'b00, 32'd7, 32'd6, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b01, 32'd100, 32'd7, 1'b0);
    run_op(2'b01, 32'd5, 32'd0, 1'b1);
    run_op(2'b10, 32'hFFFF_FFFD, 32'd5, 1'b0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd0, 1'b0);

    // Abort mid-operation: result discarded, HI/LO cleared, no done afterwards
    @(negedge clk);
    issue(2'b00, 32'hDEAD_BEEF, 32'h1234_5678, 1);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    sb.delete();
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: a = 32'h8000_0000;
        default: ;
      endcase
      run_op(2'($urandom), a, b, 1'($urandom));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
